// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a registered one-hot grant that is held until ack or
// until the optional hold timer expires; the pointer advances past each released line.
module rr_grant_arbiter #(
    parameter int LINES   = 16,
    parameter int TIMEOUT = 255,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LINES-1:0] req,
    input  logic             ack,
    output logic [LINES-1:0] grant,
    output logic             grant_valid,
    output logic             timeout
);

    localparam int PW    = $clog2(LINES);
    localparam int CNT_W = (CW < 1) ? 1 : CW;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [LINES-1:0] LINE_ONE = LINES'(1);
    localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
    localparam logic [PW-1:0]    PTR_LAST = PW'(LINES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [0:0]       r_state;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [LINES-1:0] r_grant;
    logic             r_timeout;

    logic [LINES-1:0] w_mask;
    logic [LINES-1:0] w_upper;
    logic [LINES-1:0] w_pick;
    logic [LINES-1:0] w_onehot;
    logic [PW-1:0]    w_idx;
    logic [PW-1:0]    w_next_ptr;
    logic             w_expire;

    // Lines at or above the pointer get first pick; otherwise fall back to the wrapped scan.
    for (genvar gi = 0; gi < LINES; gi++) begin : g_mask
        assign w_mask[gi] = (int'(r_ptr) <= gi);
    end

    assign w_upper  = req & w_mask;
    assign w_pick   = (|w_upper) ? w_upper : req;
    assign w_onehot = w_pick & (~w_pick + LINE_ONE);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < LINES; i++) begin
            if (w_onehot[i]) begin
                w_idx = PW'(i);
            end
        end
    end

    assign w_next_ptr = (r_idx == PTR_LAST) ? '0 : r_idx + PTR_ONE;
    assign w_expire   = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_grant   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (|req) begin
                    r_grant <= w_onehot;
                    r_idx   <= w_idx;
                    r_cnt   <= '0;
                    r_state <= ST_BUSY;
                end
            end else begin
                if (ack || w_expire) begin
                    // ack wins over a simultaneous expiry, so no timeout pulse then.
                    r_grant   <= '0;
                    r_ptr     <= w_next_ptr;
                    r_cnt     <= '0;
                    r_state   <= ST_IDLE;
                    r_timeout <= ~ack;
                end else begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end
        end
    end

    assign grant       = r_grant;
    assign grant_valid = |r_grant;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed vector table, asynchronous reset mid-grant, and a randomized run
// checked cycle by cycle against a behavioural round-robin model.
module tb_rr_grant_arbiter;

    localparam int LINES   = 16;
    localparam int TIMEOUT = 4;

    logic              clk;
    logic              rst;
    logic [LINES-1:0]  req;
    logic              ack;
    logic [LINES-1:0]  grant;
    logic              grant_valid;
    logic              timeout;

    int n_tests = 0;
    int n_fail  = 0;

    rr_grant_arbiter #(
        .LINES   (LINES),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .ack         (ack),
        .grant       (grant),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic        ack;
        logic [15:0] exp_grant;
        logic        exp_to;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic r, input logic [15:0] rq, input logic a,
                     input logic [15:0] g, input logic t);
        vec_t e;
        e.rst = r; e.req = rq; e.ack = a; e.exp_grant = g; e.exp_to = t;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string name, input logic [15:0] g, input logic t);
        chk({name, ".grant"}, 32'(grant), 32'(g));
        chk({name, ".valid"}, 32'(grant_valid), 32'(g != 16'h0));
        chk({name, ".timeout"}, 32'(timeout), 32'(t));
    endtask

    // Behavioural model state for the randomized run
    logic        m_busy;
    int          m_idx;
    int          m_ptr;
    int          m_cnt;
    logic [15:0] m_grant;
    logic        m_to;
    int          m_wait[LINES];

    task automatic model_release(input logic to);
        m_busy  = 1'b0;
        m_grant = '0;
        m_ptr   = (m_idx + 1) % LINES;
        m_cnt   = 0;
        m_to    = to;
    endtask

    task automatic model_step(input logic [15:0] rq, input logic a);
        int worst;
        m_to = 1'b0;
        for (int i = 0; i < LINES; i++) if (!rq[i]) m_wait[i] = 0;
        if (!m_busy) begin
            if (rq != 16'h0) begin
                for (int k = LINES - 1; k >= 0; k--) begin
                    if (rq[(m_ptr + k) % LINES]) m_idx = (m_ptr + k) % LINES;
                end
                m_grant = 16'h1 << m_idx;
                m_busy  = 1'b1;
                m_cnt   = 0;
                worst = 0;
                for (int i = 0; i < LINES; i++) begin
                    if (i == m_idx) m_wait[i] = 0;
                    else if (rq[i]) m_wait[i]++;
                    if (m_wait[i] > worst) worst = m_wait[i];
                end
                n_tests++;
                if (worst >= LINES) begin
                    n_fail++;
                    $display("FAIL fairness: a line waited %0d grants, limit %0d", worst, LINES - 1);
                end
            end
        end else if (a) begin
            model_release(1'b0);
        end else if (m_cnt == TIMEOUT - 1) begin
            model_release(1'b1);
        end else begin
            m_cnt++;
        end
    endtask

    initial begin
        logic [15:0] rq;
        rst = 1'b1;
        req = '0;
        ack = 1'b0;

        // Idle with reset released; ack must be ignored while idle
        v(1, 16'h0000, 0, 16'h0000, 0);
        for (int i = 0; i < 10; i++) v(0, 16'h0000, logic'(i % 3 == 0), 16'h0000, 0);
        // Single requester, ack on third grant cycle, re-grant after turnaround
        v(0, 16'h0001, 0, 16'h0001, 0);
        v(0, 16'h0001, 0, 16'h0001, 0);
        v(0, 16'h0001, 0, 16'h0001, 0);
        v(0, 16'h0001, 1, 16'h0000, 0);
        v(0, 16'h0001, 0, 16'h0001, 0);
        v(0, 16'h0001, 1, 16'h0000, 0);
        v(0, 16'h0000, 0, 16'h0000, 0);
        // Round-robin over 0x8421 from pointer 0, including the wrap
        v(1, 16'h0000, 0, 16'h0000, 0);
        v(0, 16'h8421, 0, 16'h0001, 0);
        v(0, 16'h8421, 1, 16'h0000, 0);
        v(0, 16'h8421, 0, 16'h0020, 0);
        v(0, 16'h8421, 1, 16'h0000, 0);
        v(0, 16'h8421, 0, 16'h0400, 0);
        v(0, 16'h8421, 1, 16'h0000, 0);
        v(0, 16'h8421, 0, 16'h8000, 0);
        v(0, 16'h8421, 1, 16'h0000, 0);
        v(0, 16'h8421, 0, 16'h0001, 0);
        v(0, 16'h8421, 1, 16'h0000, 0);
        v(0, 16'h0000, 0, 16'h0000, 0);
        // Hold timeout: four grant cycles then a one-cycle timeout pulse
        for (int i = 0; i < 4; i++) v(0, 16'h0010, 0, 16'h0010, 0);
        v(0, 16'h0010, 0, 16'h0000, 1);
        v(0, 16'h0010, 0, 16'h0010, 0);
        for (int i = 0; i < 3; i++) v(0, 16'h0030, 0, 16'h0010, 0);
        v(0, 16'h0030, 0, 16'h0000, 1);
        // Pointer now 5: line 5 wins over line 4
        v(0, 16'h0030, 0, 16'h0020, 0);
        for (int i = 0; i < 3; i++) v(0, 16'h0030, 0, 16'h0020, 0);
        // ack coincident with expiry: plain release, no timeout pulse
        v(0, 16'h0030, 1, 16'h0000, 0);
        v(0, 16'h0000, 0, 16'h0000, 0);
        v(0, 16'h0001, 1, 16'h0001, 0);
        v(0, 16'h0001, 1, 16'h0000, 0);
        v(0, 16'h0000, 0, 16'h0000, 0);

        @(negedge clk);
        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            req = vecs[i].req;
            ack = vecs[i].ack;
            @(negedge clk);
            chk($sformatf("vec%0d", i), grant, vecs[i].exp_grant);
            chk($sformatf("vec%0d.valid", i), 32'(grant_valid), 32'(vecs[i].exp_grant != 16'h0));
            chk($sformatf("vec%0d.timeout", i), 32'(timeout), 32'(vecs[i].exp_to));
        end

        // Asynchronous reset while holding 0x0400 (pointer is 1 here)
        rst = 1'b0; req = 16'h0400; ack = 1'b0;
        @(negedge clk);
        chk_outputs("pre_rst", 16'h0400, 1'b0);
        #2 rst = 1'b1;
        #1 chk_outputs("async_rst", 16'h0000, 1'b0);
        @(negedge clk);
        chk_outputs("in_rst", 16'h0000, 1'b0);
        rst = 1'b0; req = 16'h0401;
        @(negedge clk);
        chk_outputs("post_rst", 16'h0001, 1'b0);
        ack = 1'b1;
        @(negedge clk);
        chk_outputs("post_rst_rel", 16'h0000, 1'b0);

        // Randomized run against the model
        rst = 1'b1; req = '0; ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_busy = 1'b0; m_idx = 0; m_ptr = 0; m_cnt = 0; m_grant = '0; m_to = 1'b0;
        for (int i = 0; i < LINES; i++) m_wait[i] = 0;
        rq = 16'h0;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < LINES; b++) begin
                if ($urandom_range(0, 31) == 0) rq[b] = ~rq[b];
            end
            req = rq;
            ack = ($urandom_range(0, 3) == 0);
            model_step(rq, ack);
            @(negedge clk);
            n_tests++;
            if (grant !== m_grant || timeout !== m_to || grant_valid !== (m_grant != 16'h0)
                || !$onehot0(grant)) begin
                n_fail++;
                $display("FAIL rand cycle %0d: grant=%h valid=%b to=%b expected grant=%h valid=%b to=%b",
                         c, grant, grant_valid, timeout, m_grant, (m_grant != 16'h0), m_to);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
